hcms_frame_feeder: RTL and testbench
====================================

// Module: hcms_frame_feeder
// PURPOSE
//  Upstream byte source for hcms_serial. Holds an ASCII character buffer and a 5x7 font ROM.
//  Runs the HCMS-29xx power-up sequence: display reset, then control words 0 and 1.
//  Then streams 5 column bytes per character to the serialiser over the load/ready handshake.
//  Frames the latch so that one full display refresh is committed per frame.
// PARAMETERS
//  NUM_CHARS     4      display characters in the chain (buffer depth; frame = 5*NUM_CHARS bytes)
//  PEAK_CURRENT  2'b10  control word 0 bits [5:4]
//  RESET_CYCLES  16     i_clk cycles o_ds_reset is held after r_reset / power-up
// PORTS
//  i_clk         in   1   clock; all logic on posedge
//  r_reset       in   1   reset, synchronous, active-high
//  i_char_we     in   1   write strobe for the character buffer
//  i_char_addr   in   clog2(NUM_CHARS)  buffer slot; 0 = first character shifted out
//  i_char        in   8   ASCII code
//  i_brightness  in   4   control word 0 bits [3:0]
//  i_refresh     in   1   pulse: force a frame even if the buffer is not dirty
//  i_ready       in   1   serialiser done flag; high after a byte is shifted, low once o_load drops
//  o_data        out  8   byte to serialise
//  o_cmd         out  1   1 = control register, 0 = dot register
//  o_load        out  1   byte request
//  o_latch_enable out 1   1 = nCE released between bytes (latch); 0 = hold nCE across bytes
//  o_ds_reset    out  1   display reset request (active-high)
//  o_busy        out  1   high in every state except IDLE
//  o_frame_done  out  1   one-cycle pulse when a frame latch completes
// BEHAVIOUR
//  Reset values
//   o_data=0, o_cmd=0, o_load=0, o_latch_enable=1, o_ds_reset=1, o_busy=1, o_frame_done=0.
//   Buffer filled with 8'h20. dirty=1. Stored brightness = i_brightness.
//  Reset priority
//   r_reset mid-operation aborts the current byte: o_load drops the next cycle and the sequence restarts at RST_HOLD.
//  States
//   RST_HOLD: o_ds_reset=1 for RESET_CYCLES cycles -> CW0.
//   CW0: byte {1'b0,1'b1,PEAK_CURRENT,bright}, o_cmd=1, o_latch_enable=1 -> CW1 (initial pass) or IDLE (brightness update).
//   CW1: byte 8'h80 (serial mode, prescale 1), o_cmd=1, o_latch_enable=1 -> IDLE.
//   IDLE: o_busy=0. Priority order: (1) i_brightness differs from the stored value -> CW0 and latch the new value;
//     (2) dirty or i_refresh -> DATA with dirty cleared.
//   DATA: byte index k = 0..5*NUM_CHARS-1, sent in character order, column 0 first.
//     o_data = font[buf[k/5]][k%5], o_cmd=0, o_latch_enable=0.
//   LATCH: after the last DATA byte, o_latch_enable=1 for 2 cycles. o_frame_done pulses on exit -> IDLE.
//  Byte handshake (every byte)
//   Present o_data/o_cmd/o_latch_enable and assert o_load. Hold all of them stable while i_ready=0.
//   On i_ready=1: deassert o_load the next cycle. Wait for i_ready=0 before presenting the next byte.
//   No timeout: o_load stays high indefinitely if i_ready never rises.
//  Font ROM
//   Covers 0x20..0x5F (64 glyphs x 5 columns). Bit0 = top row, bit7 = 0.
//   0x61..0x7A fold to 0x41..0x5A. Any other code yields 5 zero columns.
//  Buffer writes
//   i_char_we writes on posedge in any state, including during DATA, and sets dirty.
//   DATA reads the buffer live, so bytes already sent may be stale; the following frame corrects them.
//   A write and a frame start in the same cycle leave dirty=1.
//  Index width
//   The byte counter and character index wrap only through frame restart; no modulo arithmetic outside 0..5*NUM_CHARS-1.
// TESTING
//  Reset, i_brightness=4'hF, responder ready after 10 cycles
//   -> o_ds_reset high 16 cycles, then bytes 0x6F(cmd=1), 0x80(cmd=1).
//   -> then a 20-byte blank frame (all 0x00), o_frame_done once, o_busy=0.
//  Write "ABCD" to slots 0..3
//   -> bytes 7E 11 11 11 7E 7F 49 49 49 36 3E 41 41 41 22 7F 41 41 22 1C, all cmd=0, latch_enable=0.
//   -> then latch_enable=1 for 2 cycles and one o_frame_done pulse.
//  Write 'a' (0x61) to slot 0
//   -> first 5 bytes 7E 11 11 11 7E. Write 0x7F -> 00 x5.
//  In IDLE, change i_brightness 4'hF -> 4'h3
//   -> exactly one byte 0x63 with cmd=1. No data frame unless dirty.
//  Write slot 2 during byte 7 of a frame
//   -> current frame completes, then a second full frame carries the new glyph.
//  Assert r_reset at DATA byte 12 with o_load high
//   -> o_load=0 the next cycle, o_ds_reset=1, full init sequence repeats.
//   -> responder holding i_ready low: o_load and o_data stay stable the whole time.

Source files
------------

// File: rtl/hcms_frame_feeder.sv
// Byte source for hcms_serial: runs the HCMS-29xx power-up sequence, then streams
// 5 font columns per buffered character over the load/ready handshake.
module hcms_frame_feeder #(
  parameter int         NUM_CHARS    = 4,
  parameter logic [1:0] PEAK_CURRENT = 2'b10,
  parameter int         RESET_CYCLES = 16
) (
  input  logic                         i_clk,
  input  logic                         r_reset,
  input  logic                         i_char_we,
  input  logic [$clog2(NUM_CHARS)-1:0] i_char_addr,
  input  logic [7:0]                   i_char,
  input  logic [3:0]                   i_brightness,
  input  logic                         i_refresh,
  input  logic                         i_ready,
  output logic [7:0]                   o_data,
  output logic                         o_cmd,
  output logic                         o_load,
  output logic                         o_latch_enable,
  output logic                         o_ds_reset,
  output logic                         o_busy,
  output logic                         o_frame_done
);

  localparam int AW = $clog2(NUM_CHARS);
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_RST_HOLD = 3'd0,
    ST_CW0      = 3'd1,
    ST_CW1      = 3'd2,
    ST_IDLE     = 3'd3,
    ST_DATA     = 3'd4,
    ST_LATCH    = 3'd5
  } state_t;

  // Glyph columns packed column 0 in the top byte; bit 0 of each column is the top row.
  function automatic logic [39:0] glyph(input logic [5:0] idx);
    logic [39:0] g;
    case (idx)
      6'h00: g = 40'h0000000000;  6'h01: g = 40'h00005F0000;
      6'h02: g = 40'h0007000700;  6'h03: g = 40'h147F147F14;
      6'h04: g = 40'h242A7F2A12;  6'h05: g = 40'h2313086462;
      6'h06: g = 40'h3649562050;  6'h07: g = 40'h0005030000;
      6'h08: g = 40'h001C224100;  6'h09: g = 40'h0041221C00;
      6'h0A: g = 40'h14083E0814;  6'h0B: g = 40'h08083E0808;
      6'h0C: g = 40'h0050300000;  6'h0D: g = 40'h0808080808;
      6'h0E: g = 40'h0060600000;  6'h0F: g = 40'h2010080402;
      6'h10: g = 40'h3E5149453E;  6'h11: g = 40'h00427F4000;
      6'h12: g = 40'h4261514946;  6'h13: g = 40'h2141454B31;
      6'h14: g = 40'h1814127F10;  6'h15: g = 40'h2745454539;
      6'h16: g = 40'h3C4A494930;  6'h17: g = 40'h0171090503;
      6'h18: g = 40'h3649494936;  6'h19: g = 40'h064949291E;
      6'h1A: g = 40'h0036360000;  6'h1B: g = 40'h0056360000;
      6'h1C: g = 40'h0814224100;  6'h1D: g = 40'h1414141414;
      6'h1E: g = 40'h0041221408;  6'h1F: g = 40'h0201510906;
      6'h20: g = 40'h324979413E;  6'h21: g = 40'h7E1111117E;
      6'h22: g = 40'h7F49494936;  6'h23: g = 40'h3E41414122;
      6'h24: g = 40'h7F4141221C;  6'h25: g = 40'h7F49494941;
      6'h26: g = 40'h7F09090901;  6'h27: g = 40'h3E4149497A;
      6'h28: g = 40'h7F0808087F;  6'h29: g = 40'h00417F4100;
      6'h2A: g = 40'h2040413F01;  6'h2B: g = 40'h7F08142241;
      6'h2C: g = 40'h7F40404040;  6'h2D: g = 40'h7F020C027F;
      6'h2E: g = 40'h7F0408107F;  6'h2F: g = 40'h3E4141413E;
      6'h30: g = 40'h7F09090906;  6'h31: g = 40'h3E4151215E;
      6'h32: g = 40'h7F09192946;  6'h33: g = 40'h4649494931;
      6'h34: g = 40'h01017F0101;  6'h35: g = 40'h3F4040403F;
      6'h36: g = 40'h1F2040201F;  6'h37: g = 40'h3F4038403F;
      6'h38: g = 40'h6314081463;  6'h39: g = 40'h0708700807;
      6'h3A: g = 40'h6151494543;  6'h3B: g = 40'h007F414100;
      6'h3C: g = 40'h0204081020;  6'h3D: g = 40'h0041417F00;
      6'h3E: g = 40'h0402010204;  6'h3F: g = 40'h4040404040;
      default: g = 40'h0000000000;
    endcase
    return g;
  endfunction

  // Lower case folds onto upper case; codes outside the ROM give blank columns.
  function automatic logic [7:0] font_col(input logic [7:0] code, input logic [2:0] col);
    logic [7:0]  c;
    logic [39:0] g;
    logic [7:0]  r;
    if (code >= 8'h61 && code <= 8'h7A) c = code - 8'h20;
    else                                c = code;
    if (c >= 8'h20 && c <= 8'h5F) g = glyph(6'(c - 8'h20));
    else                          g = 40'h0000000000;
    case (col)
      3'd0:    r = g[39:32];
      3'd1:    r = g[31:24];
      3'd2:    r = g[23:16];
      3'd3:    r = g[15:8];
      3'd4:    r = g[7:0];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic          wait_q, wait_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] chr_q, chr_d;
  logic [2:0]    col_q, col_d;
  logic          init_q, init_d;
  logic [3:0]    bright_q, bright_d;
  logic          dirty_q, dirty_d;
  logic [7:0]    char_q [NUM_CHARS];
  logic [7:0]    data_q, data_d;
  logic          cmd_q, cmd_d, load_q, load_d, le_q, le_d;
  logic          ds_reset_q, ds_reset_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic          present_s, byte_done_s, is_byte_s;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    cnt_d        = cnt_q;
    chr_d        = chr_q;
    col_d        = col_q;
    init_d       = init_q;
    bright_d     = bright_q;
    dirty_d      = dirty_q;
    present_s    = 1'b0;
    frame_done_d = 1'b0;
    is_byte_s    = (state_q == ST_CW0) || (state_q == ST_CW1) || (state_q == ST_DATA);
    byte_done_s  = is_byte_s && wait_q && !i_ready;
    // Byte handshake: ready ends the request, ready low again frees the next byte.
    if (is_byte_s && !wait_q && i_ready) wait_d = 1'b1;
    else                                 wait_d = wait_q;
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d   = ST_CW0;
          present_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CW0: begin
        if (byte_done_s) begin
          if (init_q) begin
            state_d   = ST_CW1;
            present_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CW1: begin
        if (byte_done_s) begin
          state_d = ST_IDLE;
          wait_d  = 1'b0;
          init_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_IDLE: begin
        if (i_brightness != bright_q) begin
          state_d   = ST_CW0;
          bright_d  = i_brightness;
          present_s = 1'b1;
        end else if (dirty_q || i_refresh) begin
          state_d   = ST_DATA;
          chr_d     = '0;
          col_d     = 3'd0;
          dirty_d   = 1'b0;
          present_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (byte_done_s) begin
          if (col_q != 3'd4) begin
            col_d     = col_q + 3'd1;
            present_s = 1'b1;
          end else if (chr_q != AW'(NUM_CHARS - 1)) begin
            chr_d     = chr_q + AW'(1);
            col_d     = 3'd0;
            present_s = 1'b1;
          end else begin
            state_d = ST_LATCH;
            wait_d  = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LATCH: begin
        if (cnt_q == CW'(1)) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = '0;
      end
    endcase
    if (present_s) wait_d = 1'b0;
    else           wait_d = wait_d;
    // A write in the same cycle as a frame start must survive the clear.
    dirty_d = dirty_d | i_char_we;

    load_d     = ((state_d == ST_CW0) || (state_d == ST_CW1) || (state_d == ST_DATA)) && !wait_d;
    cmd_d      = (state_d == ST_CW0) || (state_d == ST_CW1);
    le_d       = (state_d != ST_DATA);
    ds_reset_d = (state_d == ST_RST_HOLD);
    busy_d     = (state_d != ST_IDLE);
    data_d     = data_q;
    if (present_s) begin
      case (state_d)
        ST_CW0:  data_d = {1'b0, 1'b1, PEAK_CURRENT, bright_d};
        ST_CW1:  data_d = 8'h80;
        ST_DATA: data_d = font_col(char_q[chr_d], col_d);
        default: data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Control, buffer and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (r_reset) begin
      state_q      <= ST_RST_HOLD;
      wait_q       <= 1'b0;
      cnt_q        <= '0;
      chr_q        <= '0;
      col_q        <= 3'd0;
      init_q       <= 1'b1;
      bright_q     <= i_brightness;
      dirty_q      <= 1'b1;
      for (int i = 0; i < NUM_CHARS; i++) char_q[i] <= 8'h20;
      data_q       <= 8'h00;
      cmd_q        <= 1'b0;
      load_q       <= 1'b0;
      le_q         <= 1'b1;
      ds_reset_q   <= 1'b1;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cnt_q        <= cnt_d;
      chr_q        <= chr_d;
      col_q        <= col_d;
      init_q       <= init_d;
      bright_q     <= bright_d;
      dirty_q      <= dirty_d;
      if (i_char_we) char_q[i_char_addr] <= i_char;
      data_q       <= data_d;
      cmd_q        <= cmd_d;
      load_q       <= load_d;
      le_q         <= le_d;
      ds_reset_q   <= ds_reset_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_data         = data_q;
  assign o_cmd          = cmd_q;
  assign o_load         = load_q;
  assign o_latch_enable = le_q;
  assign o_ds_reset     = ds_reset_q;
  assign o_busy         = busy_q;
  assign o_frame_done   = frame_done_q;

endmodule

// File: tb/tb_hcms_frame_feeder.sv
// Directed bench for hcms_frame_feeder: a serialiser responder model collects every
// presented byte, and expected bytes come from hand-computed font tables.
module tb_hcms_frame_feeder;

  logic       i_clk = 1'b0;
  logic       r_reset = 1'b1;
  logic       i_char_we = 1'b0;
  logic [1:0] i_char_addr = 2'd0;
  logic [7:0] i_char = 8'h00;
  logic [3:0] i_brightness = 4'hF;
  logic       i_refresh = 1'b0;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_cmd, o_load, o_latch_enable, o_ds_reset, o_busy, o_frame_done;

  hcms_frame_feeder #(.NUM_CHARS(4), .PEAK_CURRENT(2'b10), .RESET_CYCLES(16)) dut (
    .i_clk(i_clk), .r_reset(r_reset), .i_char_we(i_char_we), .i_char_addr(i_char_addr),
    .i_char(i_char), .i_brightness(i_brightness), .i_refresh(i_refresh), .i_ready(i_ready),
    .o_data(o_data), .o_cmd(o_cmd), .o_load(o_load), .o_latch_enable(o_latch_enable),
    .o_ds_reset(o_ds_reset), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  code;
    logic [39:0] cols;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [9:0] q[$];   // {data, cmd, latch_enable} per presented byte
  int fd_cnt = 0, latch_cyc = 0, stab_viol = 0, rcnt = 0, rdelay = 10;
  bit stall = 1'b0;
  logic load_prev = 1'b0;
  logic [9:0] prev_byte = 10'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then update the responder.
  task automatic step();
    @(posedge i_clk);
    #1;
    if (o_load && !load_prev) q.push_back({o_data, o_cmd, o_latch_enable});
    if (o_load && load_prev && ({o_data, o_cmd, o_latch_enable} != prev_byte)) stab_viol++;
    if (o_frame_done) fd_cnt++;
    if (o_busy && !o_load && o_latch_enable && !o_cmd && !o_ds_reset) latch_cyc++;
    load_prev = o_load;
    prev_byte = {o_data, o_cmd, o_latch_enable};
    if (o_load) begin
      rcnt++;
      if (!stall && rcnt >= rdelay) i_ready = 1'b1;
    end else begin
      i_ready = 1'b0;
      rcnt = 0;
    end
  endtask

  task automatic clear_mon();
    q.delete();
    fd_cnt = 0;
    latch_cyc = 0;
    stab_viol = 0;
  endtask

  task automatic wait_frames(input string nm, input int n, input int maxc);
    int t = 0;
    while (fd_cnt < n && t < maxc) begin
      step();
      t++;
    end
    chk({nm, "_frame_timeout"}, 64'(fd_cnt >= n), 64'd1);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic write_char(input logic [1:0] a, input logic [7:0] c);
    i_char_we = 1'b1;
    i_char_addr = a;
    i_char = c;
    step();
    i_char_we = 1'b0;
  endtask

  function automatic logic [39:0] slot_cols(input int base);
    logic [39:0] r = 40'd0;
    for (int i = 0; i < 5; i++) if (base + i < q.size()) r = {r[31:0], q[base + i][9:2]};
    return r;
  endfunction

  // Release reset, check the reset hold length and the init + blank-frame sequence.
  task automatic init_run(input string nm, input logic [7:0] cw0);
    int ds_cnt = 0;
    int t = 0;
    int bad = 0;
    r_reset = 1'b0;
    while (fd_cnt < 1 && t < 1000) begin
      if (o_ds_reset) ds_cnt++;
      step();
      t++;
    end
    chk({nm, "_frame_timeout"}, 64'(fd_cnt >= 1), 64'd1);
    for (int i = 0; i < 4; i++) step();
    chk({nm, "_ds_reset_cycles"}, 64'(ds_cnt), 64'd16);
    chk({nm, "_byte_count"}, 64'(q.size()), 64'd22);
    if (q.size() >= 22) begin
      chk({nm, "_cw0"}, 64'(q[0]), 64'({cw0, 1'b1, 1'b1}));
      chk({nm, "_cw1"}, 64'(q[1]), 64'({8'h80, 1'b1, 1'b1}));
      for (int i = 2; i < 22; i++) if (q[i] != 10'd0) bad++;
      chk({nm, "_blank_frame"}, 64'(bad), 64'd0);
    end
    chk({nm, "_frame_done"}, 64'(fd_cnt), 64'd1);
    chk({nm, "_latch_cycles"}, 64'(latch_cyc), 64'd2);
    chk({nm, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    vec_t vecs[8];
    logic [39:0] abcd[4];
    int bad;
    int t;
    vecs[0] = '{8'h61, 40'h7E1111117E};
    vecs[1] = '{8'h7F, 40'h0000000000};
    vecs[2] = '{8'h30, 40'h3E5149453E};
    vecs[3] = '{8'h7A, 40'h6151494543};
    vecs[4] = '{8'h5F, 40'h4040404040};
    vecs[5] = '{8'h21, 40'h00005F0000};
    vecs[6] = '{8'h80, 40'h0000000000};
    vecs[7] = '{8'h1F, 40'h0000000000};
    abcd[0] = 40'h7E1111117E;
    abcd[1] = 40'h7F49494936;
    abcd[2] = 40'h3E41414122;
    abcd[3] = 40'h7F4141221C;

    // Reset values
    for (int i = 0; i < 3; i++) step();
    chk("reset_outputs", 64'({o_data, o_cmd, o_load, o_latch_enable, o_ds_reset, o_busy, o_frame_done}),
        64'({8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}));
    clear_mon();
    init_run("init", 8'h6F);
    chk("init_stable", 64'(stab_viol), 64'd0);

    // "ABCD": later writes land after the frame starts, so two identical frames follow.
    clear_mon();
    for (int i = 0; i < 4; i++) write_char(2'(i), 8'h41 + 8'(i));
    wait_frames("abcd", 2, 3000);
    chk("abcd_byte_count", 64'(q.size()), 64'd40);
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 4; s++)
        chk($sformatf("abcd_f%0d_slot%0d", f, s), 64'(slot_cols(20 * f + 5 * s)), 64'(abcd[s]));
    bad = 0;
    foreach (q[i]) if (q[i][1:0] != 2'b00) bad++;
    chk("abcd_cmd_le_zero", 64'(bad), 64'd0);
    chk("abcd_latch_cycles", 64'(latch_cyc), 64'd4);
    chk("abcd_frame_done", 64'(fd_cnt), 64'd2);

    // Font table vectors through slot 0
    foreach (vecs[v]) begin
      clear_mon();
      write_char(2'd0, vecs[v].code);
      wait_frames($sformatf("vec%0d", v), 1, 1500);
      chk($sformatf("vec%0d_code%0h", v, vecs[v].code), 64'(slot_cols(0)), 64'(vecs[v].cols));
      chk($sformatf("vec%0d_slot1", v), 64'(slot_cols(5)), 64'(abcd[1]));
    end

    // Brightness change in IDLE: one control word, no frame.
    clear_mon();
    i_brightness = 4'h3;
    for (int i = 0; i < 80; i++) step();
    chk("bright_byte_count", 64'(q.size()), 64'd1);
    if (q.size() >= 1) chk("bright_cw0", 64'(q[0]), 64'({8'h63, 1'b1, 1'b1}));
    chk("bright_no_frame", 64'(fd_cnt), 64'd0);
    chk("bright_busy", 64'(o_busy), 64'd0);

    // Write slot 2 while byte 7 is outstanding.
    clear_mon();
    i_refresh = 1'b1;
    step();
    i_refresh = 1'b0;
    t = 0;
    while (q.size() < 8 && t < 500) begin step(); t++; end
    chk("midwrite_reach_byte7", 64'(q.size()), 64'd8);
    write_char(2'd2, 8'h45);
    wait_frames("midwrite", 2, 3000);
    chk("midwrite_byte_count", 64'(q.size()), 64'd40);
    chk("midwrite_f1_slot1", 64'(slot_cols(5)), 64'(abcd[1]));
    chk("midwrite_f2_slot2", 64'(slot_cols(30)), 64'h7F49494941);

    // Reset at byte 12 while the responder stalls.
    clear_mon();
    i_refresh = 1'b1;
    step();
    i_refresh = 1'b0;
    t = 0;
    while (q.size() < 13 && t < 500) begin step(); t++; end
    chk("rst_reach_byte12", 64'(q.size()), 64'd13);
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("stall_load_data", 64'({o_load, o_data}), 64'({1'b1, 8'h49}));
    chk("stall_stable", 64'(stab_viol), 64'd0);
    r_reset = 1'b1;
    step();
    chk("rst_abort", 64'({o_load, o_ds_reset, o_busy}), 64'({1'b0, 1'b1, 1'b1}));
    stall = 1'b0;
    clear_mon();
    init_run("reinit", 8'h63);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
